// File: rtl/id_exe_stage_reg.sv
// ID->EXE pipeline register with freeze, flush and hazard bubble.
// Optional saturating perf counters: define ID_REG_PERF_CNT_EN.
module id_exe_stage_reg #(
   parameter int ADDRESS_LEN = 32,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   freeze,
   input  logic                   flush,
   input  logic                   hazard,
   input  logic [ADDRESS_LEN-1:0] pc_in,
   input  logic                   WB_EN_in,
   input  logic                   MEM_R_EN_in,
   input  logic                   MEM_W_EN_in,
   input  logic                   B_in,
   input  logic                   S_in,
   input  logic [3:0]             EXE_CMD_in,
   input  logic [ADDRESS_LEN-1:0] Val_Rn_in,
   input  logic [ADDRESS_LEN-1:0] Val_Rm_in,
   input  logic                   imm_in,
   input  logic [11:0]            Shift_operand_in,
   input  logic [23:0]            Signed_imm_24_in,
   input  logic [3:0]             Dest_in,
   input  logic [3:0]             src1_in,
   input  logic [3:0]             src2_in,
   input  logic                   C_in,
   output logic [ADDRESS_LEN-1:0] pc_out,
   output logic                   WB_EN_out,
   output logic                   MEM_R_EN_out,
   output logic                   MEM_W_EN_out,
   output logic                   B_out,
   output logic                   S_out,
   output logic [3:0]             EXE_CMD_out,
   output logic [ADDRESS_LEN-1:0] Val_Rn_out,
   output logic [ADDRESS_LEN-1:0] Val_Rm_out,
   output logic                   imm_out,
   output logic [11:0]            Shift_operand_out,
   output logic [23:0]            Signed_imm_24_out,
   output logic [3:0]             Dest_out,
   output logic [3:0]             src1_out,
   output logic [3:0]             src2_out,
   output logic                   C_out,
`ifdef ID_REG_PERF_CNT_EN
   output logic [CNT_W-1:0]       bubble_cnt,
   output logic [CNT_W-1:0]       flush_cnt,
   output logic [CNT_W-1:0]       issue_cnt,
`endif
   output logic                   valid_out
);

   typedef struct packed {
      logic [ADDRESS_LEN-1:0] pc;
      logic                   wb_en;
      logic                   mem_r_en;
      logic                   mem_w_en;
      logic                   b;
      logic                   s;
      logic [3:0]             exe_cmd;
      logic [ADDRESS_LEN-1:0] val_rn;
      logic [ADDRESS_LEN-1:0] val_rm;
      logic                   imm;
      logic [11:0]            shift_operand;
      logic [23:0]            signed_imm_24;
      logic [3:0]             dest;
      logic [3:0]             src1;
      logic [3:0]             src2;
      logic                   c;
      logic                   valid;
   } slot_t;

   slot_t slot_d, slot_q, slot_in;

   always_comb begin
      slot_in               = '0;
      slot_in.pc            = pc_in;
      slot_in.wb_en         = WB_EN_in;
      slot_in.mem_r_en      = MEM_R_EN_in;
      slot_in.mem_w_en      = MEM_W_EN_in;
      slot_in.b             = B_in;
      slot_in.s             = S_in;
      slot_in.exe_cmd       = EXE_CMD_in;
      slot_in.val_rn        = Val_Rn_in;
      slot_in.val_rm        = Val_Rm_in;
      slot_in.imm           = imm_in;
      slot_in.shift_operand = Shift_operand_in;
      slot_in.signed_imm_24 = Signed_imm_24_in;
      slot_in.dest          = Dest_in;
      slot_in.src1          = src1_in;
      slot_in.src2          = src2_in;
      slot_in.c             = C_in;
      slot_in.valid         = 1'b1;
   end

   // Bubble keeps data fields but strips every side effect.
   always_comb begin
      slot_d = slot_q;
      if (flush) begin
         slot_d = '0;
      end else if (freeze) begin
         slot_d = slot_q;
      end else if (hazard) begin
         slot_d          = slot_in;
         slot_d.wb_en    = 1'b0;
         slot_d.mem_r_en = 1'b0;
         slot_d.mem_w_en = 1'b0;
         slot_d.b        = 1'b0;
         slot_d.s        = 1'b0;
         slot_d.exe_cmd  = 4'd0;
         slot_d.valid    = 1'b0;
      end else begin
         slot_d = slot_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) slot_q <= '0;
      else      slot_q <= slot_d;
   end

   assign pc_out            = slot_q.pc;
   assign WB_EN_out         = slot_q.wb_en;
   assign MEM_R_EN_out      = slot_q.mem_r_en;
   assign MEM_W_EN_out      = slot_q.mem_w_en;
   assign B_out             = slot_q.b;
   assign S_out             = slot_q.s;
   assign EXE_CMD_out       = slot_q.exe_cmd;
   assign Val_Rn_out        = slot_q.val_rn;
   assign Val_Rm_out        = slot_q.val_rm;
   assign imm_out           = slot_q.imm;
   assign Shift_operand_out = slot_q.shift_operand;
   assign Signed_imm_24_out = slot_q.signed_imm_24;
   assign Dest_out          = slot_q.dest;
   assign src1_out          = slot_q.src1;
   assign src2_out          = slot_q.src2;
   assign C_out             = slot_q.c;
   assign valid_out         = slot_q.valid;

`ifdef ID_REG_PERF_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
   logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
   logic [CNT_W-1:0] issue_cnt_d, issue_cnt_q;
   logic             is_bubble, is_issue;

   assign is_bubble = !flush && !freeze && hazard;
   assign is_issue  = !flush && !freeze && !hazard;

   // Counters saturate at all-ones rather than wrapping.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      issue_cnt_d  = issue_cnt_q;
      if (is_bubble && bubble_cnt_q != '1)
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      if (flush && flush_cnt_q != '1)
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      if (is_issue && issue_cnt_q != '1)
         issue_cnt_d = issue_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bubble_cnt_q <= '0;
         flush_cnt_q  <= '0;
         issue_cnt_q  <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         issue_cnt_q  <= issue_cnt_d;
      end
   end

   assign bubble_cnt = bubble_cnt_q;
   assign flush_cnt  = flush_cnt_q;
   assign issue_cnt  = issue_cnt_q;
`endif

endmodule
